// File: rtl/pipe_ctrl_path_pkg.sv
// Shared definitions for the pipeline control path: ALUOp and opcode codes,
// control-bundle layout and the per-stage control structs.
package pipe_ctrl_path_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] ALUOP_LWSW  = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Bit positions of the decoder bundle, MSB first.
    localparam int BIT_REG_WRITE  = 8;
    localparam int BIT_MEM_TO_REG = 7;
    localparam int BIT_MEM_WRITE  = 6;
    localparam int BIT_MEM_READ   = 5;
    localparam int BIT_BRANCH     = 4;
    localparam int BIT_ALU_SRC    = 3;
    localparam int BIT_REG_DST    = 2;
    localparam int BIT_ALU_OP_HI  = 1;
    localparam int BIT_ALU_OP_LO  = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } id_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam int IDEX_CTRL_W  = $bits(id_ctrl_t);
    localparam int EXMEM_CTRL_W = $bits(mem_ctrl_t);
    localparam int MEMWB_CTRL_W = $bits(wb_ctrl_t);

    // An invalid ID slot contributes no control at all, so unknown decoder
    // outputs for an illegal opcode never reach the pipeline.
    function automatic id_ctrl_t sanitize_ctrl(input logic valid, input id_ctrl_t c);
        return valid ? c : id_ctrl_t'('0);
    endfunction

endpackage

// File: rtl/pipe_ctrl_path_stage.sv
// One pipeline boundary register: control field plus register-address field.
// A bubble zeroes only the control; the address field is don't-care then.
module pipe_ctrl_stage #(
    parameter int CTRL_W = 1,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    // Stage register: advances every cycle, control cleared on bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= bubble ? '0 : ctrl_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_path.sv
// Control path of the 5-stage MIPS pipeline: carries decoded control from ID
// to WB and owns load-use stall and taken-branch squash.
module pipe_ctrl_path
    import pipe_ctrl_path_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_RegWrite,
    input  logic              id_MemtoReg,
    input  logic              id_MemWrite,
    input  logic              id_MemRead,
    input  logic              id_Branch,
    input  logic              id_ALUSrc,
    input  logic              id_RegDst,
    input  logic [1:0]        id_ALUOp,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_zero,
    output logic              ex_ALUSrc,
    output logic              ex_RegDst,
    output logic              ex_MemRead,
    output logic [1:0]        ex_ALUOp,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic              mem_Branch,
    output logic [REG_AW-1:0] mem_dst,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [REG_AW-1:0] wb_dst,
    output logic              stall,
    output logic              flush,
    output logic              pcsrc
);

    id_ctrl_t          id_ctrl;
    id_ctrl_t          ex_ctrl;
    mem_ctrl_t         mem_ctrl_d;
    mem_ctrl_t         mem_ctrl;
    wb_ctrl_t          wb_ctrl_d;
    wb_ctrl_t          wb_ctrl;
    logic [2*REG_AW-1:0] id_regs;
    logic [2*REG_AW-1:0] ex_regs;
    logic [REG_AW-1:0] ex_dst;
    logic              load_use;

    assign id_ctrl = sanitize_ctrl(id_valid, {id_RegWrite, id_MemtoReg, id_MemWrite,
                                              id_MemRead, id_Branch, id_ALUSrc,
                                              id_RegDst, id_ALUOp});
    // Address fields of an invalid slot are forced to 0 so they never carry X.
    assign id_regs = id_valid ? {id_rt, id_rd} : '0;

    // Load-use: the load in EX writes a register the ID instruction reads.
    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_ctrl.mem_read && (ex_rt != '0) &&
            ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
            load_use = 1'b1;
        end
    end

    assign pcsrc = mem_ctrl.branch & mem_zero;
    assign flush = pcsrc;
    // A taken branch kills the stalled instruction anyway, so it wins.
    assign stall = load_use & ~pcsrc;

    pipe_ctrl_stage #(.CTRL_W(IDEX_CTRL_W), .DATA_W(2*REG_AW)) u_id_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (load_use | pcsrc),
        .ctrl_d (id_ctrl),
        .data_d (id_regs),
        .ctrl_q (ex_ctrl),
        .data_q (ex_regs)
    );

    assign ex_rt  = ex_regs[2*REG_AW-1:REG_AW];
    assign ex_rd  = ex_regs[REG_AW-1:0];
    assign ex_dst = ex_ctrl.reg_dst ? ex_rd : ex_rt;

    assign mem_ctrl_d = '{reg_write:  ex_ctrl.reg_write,
                          mem_to_reg: ex_ctrl.mem_to_reg,
                          mem_write:  ex_ctrl.mem_write,
                          mem_read:   ex_ctrl.mem_read,
                          branch:     ex_ctrl.branch};

    pipe_ctrl_stage #(.CTRL_W(EXMEM_CTRL_W), .DATA_W(REG_AW)) u_ex_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (pcsrc),
        .ctrl_d (mem_ctrl_d),
        .data_d (ex_dst),
        .ctrl_q (mem_ctrl),
        .data_q (mem_dst)
    );

    assign wb_ctrl_d = '{reg_write:  mem_ctrl.reg_write,
                         mem_to_reg: mem_ctrl.mem_to_reg};

    // The branch itself always completes, so MEM/WB never takes a bubble.
    pipe_ctrl_stage #(.CTRL_W(MEMWB_CTRL_W), .DATA_W(REG_AW)) u_mem_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .ctrl_d (wb_ctrl_d),
        .data_d (mem_dst),
        .ctrl_q (wb_ctrl),
        .data_q (wb_dst)
    );

    assign ex_ALUSrc    = ex_ctrl.alu_src;
    assign ex_RegDst    = ex_ctrl.reg_dst;
    assign ex_MemRead   = ex_ctrl.mem_read;
    assign ex_ALUOp     = ex_ctrl.alu_op;
    assign mem_MemWrite = mem_ctrl.mem_write;
    assign mem_MemRead  = mem_ctrl.mem_read;
    assign mem_Branch   = mem_ctrl.branch;
    assign wb_RegWrite  = wb_ctrl.reg_write;
    assign wb_MemtoReg  = wb_ctrl.mem_to_reg;

endmodule

// File: tb/tb_pipe_ctrl_path.sv
// Self-checking bench for pipe_ctrl_path: table-driven straight-line code
// checked through a per-stage scoreboard, then hand sequences for reset,
// load-use, taken branch and branch-plus-hazard.
module tb_pipe_ctrl_path;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic       id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead;
    logic       id_Branch, id_ALUSrc, id_RegDst;
    logic [1:0] id_ALUOp;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       mem_zero;
    logic       ex_ALUSrc, ex_RegDst, ex_MemRead;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rt, ex_rd;
    logic       mem_MemWrite, mem_MemRead, mem_Branch;
    logic [4:0] mem_dst;
    logic       wb_RegWrite, wb_MemtoReg;
    logic [4:0] wb_dst;
    logic       stall, flush, pcsrc;

    pipe_ctrl_path #(.REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
        .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst),
        .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_zero(mem_zero),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_MemRead(ex_MemRead),
        .ex_ALUOp(ex_ALUOp), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_Branch(mem_Branch), .mem_dst(mem_dst),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
        .stall(stall), .flush(flush), .pcsrc(pcsrc)
    );

    always #5 clk = ~clk;

    // Bundle order: RegWrite MemtoReg MemWrite MemRead Branch ALUSrc RegDst ALUOp[1:0]
    localparam logic [8:0] C_R    = 9'b100000110;
    localparam logic [8:0] C_LW   = 9'b110101000;
    localparam logic [8:0] C_SW   = 9'b001001000;
    localparam logic [8:0] C_BEQ  = 9'b000010001;
    localparam logic [8:0] C_ADDI = 9'b100001000;
    localparam logic [8:0] C_NONE = 9'b000000000;

    typedef struct {
        logic       v;
        logic [8:0] ctrl;
        logic [4:0] rs, rt, rd;
        logic [8:0] exp_ctrl;
        logic [4:0] exp_dst;
    } vec_t;

    typedef struct {
        logic [4:0] c;
        logic [4:0] a;
        logic [4:0] b;
        logic       chk;
    } exp_t;

    exp_t ex_q[$];
    exp_t mem_q[$];
    exp_t wb_q[$];
    vec_t vecs[10];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] c,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v;
        {id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead, id_Branch,
         id_ALUSrc, id_RegDst, id_ALUOp} = c;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
    endtask

    task automatic idle();
        drive(1'b0, C_NONE, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input vec_t v);
        exp_t e;
        logic [8:0] ec;
        ec = v.exp_ctrl;
        e.chk = v.v;
        e.c = {ec[3], ec[2], ec[5], ec[1:0]};
        e.a = v.rt;
        e.b = v.rd;
        ex_q.push_back(e);
        e.c = {2'b00, ec[6], ec[5], ec[4]};
        e.a = v.exp_dst;
        e.b = 5'd0;
        mem_q.push_back(e);
        e.c = {3'b000, ec[8], ec[7]};
        wb_q.push_back(e);
    endtask

    task automatic push_bubble(input bit to_ex, input bit to_mem, input bit to_wb);
        exp_t e;
        e.c = '0;
        e.a = '0;
        e.b = '0;
        e.chk = 1'b0;
        if (to_ex) ex_q.push_back(e);
        if (to_mem) mem_q.push_back(e);
        if (to_wb) wb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (ex_q.size() == 0 || mem_q.size() == 0 || wb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: ex=%0d mem=%0d wb=%0d, expected all > 0",
                     ex_q.size(), mem_q.size(), wb_q.size());
        end else begin
            e = ex_q.pop_front();
            check("ex_ctrl", int'({ex_ALUSrc, ex_RegDst, ex_MemRead, ex_ALUOp}), int'(e.c));
            if (e.chk) begin
                check("ex_rt", int'(ex_rt), int'(e.a));
                check("ex_rd", int'(ex_rd), int'(e.b));
            end
            e = mem_q.pop_front();
            check("mem_ctrl", int'({mem_MemWrite, mem_MemRead, mem_Branch}), int'(e.c));
            if (e.chk) check("mem_dst", int'(mem_dst), int'(e.a));
            e = wb_q.pop_front();
            check("wb_ctrl", int'({wb_RegWrite, wb_MemtoReg}), int'(e.c));
            if (e.chk) check("wb_dst", int'(wb_dst), int'(e.a));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t prog[5];
        int   pc;
        int   stall_cnt;
        int   run;
        int   max_run;

        vecs[0] = '{1'b1, C_R,    5'd1, 5'd2,  5'd3,  C_R,    5'd3};
        vecs[1] = '{1'b1, C_LW,   5'd1, 5'd8,  5'd31, C_LW,   5'd8};
        vecs[2] = '{1'b1, C_ADDI, 5'd9, 5'd10, 5'd0,  C_ADDI, 5'd10};
        vecs[3] = '{1'b1, C_SW,   5'd4, 5'd6,  5'd0,  C_SW,   5'd6};
        vecs[4] = '{1'b0, 9'h1FF, 5'd8, 5'd8,  5'd8,  C_NONE, 5'd0};
        vecs[5] = '{1'b1, C_LW,   5'd2, 5'd0,  5'd0,  C_LW,   5'd0};
        vecs[6] = '{1'b1, C_R,    5'd0, 5'd7,  5'd11, C_R,    5'd11};
        vecs[7] = '{1'b1, C_BEQ,  5'd3, 5'd4,  5'd0,  C_BEQ,  5'd4};
        vecs[8] = '{1'b1, C_R,    5'd5, 5'd6,  5'd31, C_R,    5'd31};
        vecs[9] = '{1'b1, C_NONE, 5'd0, 5'd0,  5'd0,  C_NONE, 5'd0};

        // Reset state
        rst_n = 1'b0;
        mem_zero = 1'b0;
        drive(1'b1, C_LW, 5'd8, 5'd8, 5'd8);
        #23;
        check("rst_ex_MemRead", int'(ex_MemRead), 0);
        check("rst_ex_rt", int'(ex_rt), 0);
        check("rst_mem_dst", int'(mem_dst), 0);
        check("rst_wb_RegWrite", int'(wb_RegWrite), 0);
        check("rst_wb_dst", int'(wb_dst), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_pcsrc", int'(pcsrc), 0);
        idle();
        rst_n = 1'b1;
        step();
        step();
        step();

        // Table: straight-line code, no hazards, branch not taken
        push_bubble(1'b0, 1'b1, 1'b1);
        push_bubble(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            #1;
            check("tbl_stall", int'(stall), 0);
            check("tbl_pcsrc", int'(pcsrc), 0);
            push_vec(vecs[i]);
            step();
            pop_check();
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            push_bubble(1'b1, 1'b1, 1'b1);
            step();
            pop_check();
        end
        ex_q.delete();
        mem_q.delete();
        wb_q.delete();
        step();

        // Reset mid-stall, then first instruction after release
        drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0);
        step();
        drive(1'b1, C_R, 5'd8, 5'd9, 5'd12);
        #1;
        check("pre_rst_stall", int'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", int'(stall), 0);
        check("midrst_ex_MemRead", int'(ex_MemRead), 0);
        check("midrst_ex_rt", int'(ex_rt), 0);
        check("midrst_mem_MemRead", int'(mem_MemRead), 0);
        idle();
        #3;
        rst_n = 1'b1;
        drive(1'b1, C_R, 5'd1, 5'd2, 5'd5);
        step();
        idle();
        step();
        check("post_rst_wb_early", int'(wb_RegWrite), 0);
        step();
        check("post_rst_wb_RegWrite", int'(wb_RegWrite), 1);
        check("post_rst_wb_dst", int'(wb_dst), 5);
        step();

        // Load-use: LW r8 then ADD using r8
        drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0);
        step();
        drive(1'b1, C_R, 5'd8, 5'd9, 5'd12);
        #1;
        check("lu_stall", int'(stall), 1);
        check("lu_flush", int'(flush), 0);
        step();
        check("lu_bubble_ex_MemRead", int'(ex_MemRead), 0);
        check("lu_bubble_stall", int'(stall), 0);
        check("lu_mem_MemRead", int'(mem_MemRead), 1);
        step();
        check("lu_add_ex_RegDst", int'(ex_RegDst), 1);
        check("lu_add_ex_rd", int'(ex_rd), 12);
        check("lu_add_ex_rt", int'(ex_rt), 9);
        idle();
        step();
        step();

        // Back-to-back loads, bench acts as IF/ID honouring stall
        prog[0] = '{1'b1, C_LW, 5'd1, 5'd8, 5'd0,  C_LW, 5'd8};
        prog[1] = '{1'b1, C_LW, 5'd8, 5'd9, 5'd0,  C_LW, 5'd9};
        prog[2] = '{1'b1, C_R,  5'd9, 5'd0, 5'd3,  C_R,  5'd3};
        prog[3] = '{1'b1, C_NONE, 5'd0, 5'd0, 5'd0, C_NONE, 5'd0};
        prog[4] = '{1'b1, C_NONE, 5'd0, 5'd0, 5'd0, C_NONE, 5'd0};
        pc = 0;
        stall_cnt = 0;
        run = 0;
        max_run = 0;
        for (int cyc = 0; cyc < 12 && pc < 5; cyc++) begin
            drive(prog[pc].v, prog[pc].ctrl, prog[pc].rs, prog[pc].rt, prog[pc].rd);
            #1;
            if (stall) begin
                stall_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
                pc++;
            end
            step();
        end
        check("b2b_stall_count", stall_cnt, 2);
        check("b2b_max_stall_run", max_run, 1);
        check("b2b_program_done", pc, 5);
        idle();
        step();
        step();
        step();

        // Taken branch: BEQ, SW, ADDI; SW and ADDI are squashed
        drive(1'b1, C_BEQ, 5'd3, 5'd4, 5'd0);
        step();
        drive(1'b1, C_SW, 5'd4, 5'd6, 5'd0);
        step();
        drive(1'b1, C_ADDI, 5'd1, 5'd7, 5'd0);
        mem_zero = 1'b1;
        #1;
        check("br_pcsrc", int'(pcsrc), 1);
        check("br_flush", int'(flush), 1);
        check("br_stall", int'(stall), 0);
        step();
        mem_zero = 1'b0;
        idle();
        check("br_sw_mem_MemWrite", int'(mem_MemWrite), 0);
        check("br_addi_ex_ALUSrc", int'(ex_ALUSrc), 0);
        check("br_after_pcsrc", int'(pcsrc), 0);
        step();
        check("br_sw_wb_RegWrite", int'(wb_RegWrite), 0);
        step();
        check("br_addi_wb_RegWrite", int'(wb_RegWrite), 0);
        step();

        // Hazard and taken branch in the same cycle
        drive(1'b1, C_BEQ, 5'd3, 5'd4, 5'd0);
        step();
        drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0);
        step();
        drive(1'b1, C_R, 5'd8, 5'd2, 5'd3);
        mem_zero = 1'b1;
        #1;
        check("sim_stall", int'(stall), 0);
        check("sim_flush", int'(flush), 1);
        check("sim_pcsrc", int'(pcsrc), 1);
        step();
        mem_zero = 1'b0;
        idle();
        check("sim_lw_mem_MemRead", int'(mem_MemRead), 0);
        check("sim_add_ex_RegDst", int'(ex_RegDst), 0);
        check("sim_ex_MemRead", int'(ex_MemRead), 0);
        step();
        step();
        check("sim_add_wb_RegWrite", int'(wb_RegWrite), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
